// File: rtl/pio_arbiter.sv
// Two-master arbiter sharing one custom_pio Avalon-MM slave, one access in flight at a time.
// Define PIO_ARB_FIXED_PRIO_EN for fixed m0 priority; the default is round-robin.
module pio_arbiter #(
    parameter int unsigned AW     = 1,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_m0_addr,
    input  logic          i_m0_read,
    input  logic          i_m0_write,
    input  logic [DW-1:0] i_m0_wdata,
    output logic [DW-1:0] o_m0_rdata,
    output logic          o_m0_waitrequest,
    output logic          o_m0_readdatavalid,
    input  logic [AW-1:0] i_m1_addr,
    input  logic          i_m1_read,
    input  logic          i_m1_write,
    input  logic [DW-1:0] i_m1_wdata,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_m1_waitrequest,
    output logic          o_m1_readdatavalid,
    output logic [AW-1:0] o_s_addr,
    output logic          o_s_re,
    output logic          o_s_we,
    output logic [DW-1:0] o_s_wdata,
    input  logic [DW-1:0] i_s_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StRdRet} state_e;

    state_e        r_state;
    logic          r_gnt;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_s_addr;
    logic          r_s_re;
    logic          r_s_we;
    logic [DW-1:0] r_s_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          r_m0_wait;
    logic          r_m1_wait;
    logic          r_m0_rdv;
    logic          r_m1_rdv;
`ifndef PIO_ARB_FIXED_PRIO_EN
    logic          r_last;
`endif

    logic          w_req0;
    logic          w_req1;
    logic          w_win;
    logic          w_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_req0 = i_m0_read | i_m0_write;
    assign w_req1 = i_m1_read | i_m1_write;

    always_comb begin
        w_win = w_req1 & ~w_req0;
        if (w_req0 && w_req1) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
            w_win = 1'b0;
`else
            w_win = ~r_last;
`endif
        end
    end

    // A simultaneous read+write from one master is served as a write.
    assign w_wr    = w_win ? i_m1_write : i_m0_write;
    assign w_addr  = w_win ? i_m1_addr  : i_m0_addr;
    assign w_wdata = w_win ? i_m1_wdata : i_m0_wdata;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            r_s_addr   <= '0;
            r_s_re     <= 1'b0;
            r_s_we     <= 1'b0;
            r_s_wdata  <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_wait  <= 1'b1;
            r_m1_wait  <= 1'b1;
            r_m0_rdv   <= 1'b0;
            r_m1_rdv   <= 1'b0;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_m0_rdv <= 1'b0;
            r_m1_rdv <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req0 || w_req1) begin
                        r_gnt     <= w_win;
`ifndef PIO_ARB_FIXED_PRIO_EN
                        r_last    <= w_win;
`endif
                        r_s_addr  <= w_addr;
                        r_s_wdata <= w_wdata;
                        r_s_we    <= w_wr;
                        r_s_re    <= ~w_wr;
                        r_m0_wait <= w_win;
                        r_m1_wait <= ~w_win;
                        r_state   <= StIssue;
                    end
                end
                StIssue: begin
                    r_s_we    <= 1'b0;
                    r_s_re    <= 1'b0;
                    r_m0_wait <= 1'b1;
                    r_m1_wait <= 1'b1;
                    if (r_s_re) begin
                        r_cnt   <= 3'(RD_LAT);
                        r_state <= StRdWait;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRdWait: begin
                    r_cnt <= r_cnt - 3'd1;
                    // Slave data is valid RD_LAT cycles after the s_re cycle.
                    if (r_cnt == 3'd1) begin
                        if (r_gnt) begin
                            r_m1_rdata <= i_s_rdata;
                            r_m1_rdv   <= 1'b1;
                        end else begin
                            r_m0_rdata <= i_s_rdata;
                            r_m0_rdv   <= 1'b1;
                        end
                        r_state <= StRdRet;
                    end
                end
                StRdRet: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_s_addr           = r_s_addr;
    assign o_s_re             = r_s_re;
    assign o_s_we             = r_s_we;
    assign o_s_wdata          = r_s_wdata;
    assign o_m0_rdata         = r_m0_rdata;
    assign o_m1_rdata         = r_m1_rdata;
    assign o_m0_waitrequest   = r_m0_wait;
    assign o_m1_waitrequest   = r_m1_wait;
    assign o_m0_readdatavalid = r_m0_rdv;
    assign o_m1_readdatavalid = r_m1_rdv;

endmodule

// File: tb/tb_pio_arbiter.sv
// Bench for pio_arbiter: directed steps then random traffic against a transaction-level model.
// Honours PIO_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_pio_arbiter;
    localparam int AW     = 1;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic          m0_wait, m1_wait, m0_rdv, m1_rdv;
    logic [AW-1:0] s_addr;
    logic          s_re, s_we;
    logic [DW-1:0] s_wdata, s_rdata;

    pio_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .i_m0_addr          (m0_addr),
        .i_m0_read          (m0_read),
        .i_m0_write         (m0_write),
        .i_m0_wdata         (m0_wdata),
        .o_m0_rdata         (m0_rdata),
        .o_m0_waitrequest   (m0_wait),
        .o_m0_readdatavalid (m0_rdv),
        .i_m1_addr          (m1_addr),
        .i_m1_read          (m1_read),
        .i_m1_write         (m1_write),
        .i_m1_wdata         (m1_wdata),
        .o_m1_rdata         (m1_rdata),
        .o_m1_waitrequest   (m1_wait),
        .o_m1_readdatavalid (m1_rdv),
        .o_s_addr           (s_addr),
        .o_s_re             (s_re),
        .o_s_we             (s_we),
        .o_s_wdata          (s_wdata),
        .i_s_rdata          (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: two registers, data appears RD_LAT cycles after s_re, noise otherwise.
    logic [DW-1:0] s_mem  [2];
    logic [DW-1:0] s_pipe [RD_LAT];
    always @(posedge clk) begin
        if (s_we) s_mem[s_addr] <= s_wdata;
        s_pipe[0] <= s_re ? s_mem[s_addr] : $urandom;
        for (int i = 1; i < RD_LAT; i++) s_pipe[i] <= s_pipe[i-1];
    end
    assign s_rdata = s_pipe[RD_LAT-1];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Master-side pending requests and the transaction-level reference model.
    bit            p_rd [2];
    bit            p_wr [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    bit            rst_drv;
    int            idle_at, acc_cyc, rv_cyc, acc_m, rv_m;
    bit            acc_we, last, rst_prev;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata, rv_data;
    logic [DW-1:0] mmem [2];
    logic [DW-1:0] exp_rdata [2];
    int            grants [$];
    int            t_rv, t_acc;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        if (rv_cyc == cyc) exp_rdata[rv_m] = rv_data;
        chk1("m0_waitrequest", m0_wait, !(acc_cyc == cyc && acc_m == 0));
        chk1("m1_waitrequest", m1_wait, !(acc_cyc == cyc && acc_m == 1));
        chk1("m0_readdatavalid", m0_rdv, rv_cyc == cyc && rv_m == 0);
        chk1("m1_readdatavalid", m1_rdv, rv_cyc == cyc && rv_m == 1);
        chkw("m0_rdata", m0_rdata, exp_rdata[0]);
        chkw("m1_rdata", m1_rdata, exp_rdata[1]);
        chk1("s_we", s_we, acc_cyc == cyc && acc_we);
        chk1("s_re", s_re, acc_cyc == cyc && !acc_we);
        if (acc_cyc == cyc) begin
            chkw("s_addr", DW'(s_addr), DW'(acc_addr));
            if (acc_we) chkw("s_wdata", s_wdata, acc_wdata);
        end
        if (rst_prev) begin
            chkw("s_addr_reset", DW'(s_addr), '0);
            chkw("s_wdata_reset", s_wdata, '0);
        end
    endtask

    task automatic model_cycle();
        bit r0, r1;
        int w;
        if (acc_cyc == cyc) begin
            p_rd[acc_m] = 1'b0;
            p_wr[acc_m] = 1'b0;
            if (acc_we) begin
                mmem[acc_addr] = acc_wdata;
            end else begin
                rv_cyc  = cyc + 1 + RD_LAT;
                rv_m    = acc_m;
                rv_data = mmem[acc_addr];
            end
        end
        if (!rst_n) begin
            acc_cyc      = -1;
            rv_cyc       = -1;
            last         = 1'b1;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            idle_at      = cyc + 1;
            rst_prev     = 1'b1;
        end else begin
            rst_prev = 1'b0;
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (cyc >= idle_at && (r0 || r1)) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
                w = r0 ? 0 : 1;
`else
                if (r0 && r1) w = last ? 0 : 1;
                else          w = r0 ? 0 : 1;
`endif
                last      = (w == 1);
                acc_cyc   = cyc + 1;
                acc_m     = w;
                acc_we    = (w == 1) ? m1_write : m0_write;
                acc_addr  = (w == 1) ? m1_addr  : m0_addr;
                acc_wdata = (w == 1) ? m1_wdata : m0_wdata;
                idle_at   = acc_we ? cyc + 2 : cyc + 3 + RD_LAT;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = rst_drv;
        m0_read  = p_rd[0];
        m0_write = p_wr[0];
        m0_addr  = p_addr[0];
        m0_wdata = p_wdata[0];
        m1_read  = p_rd[1];
        m1_write = p_wr[1];
        m1_addr  = p_addr[1];
        m1_wdata = p_wdata[1];
        @(negedge clk);
        check_cycle();
        model_cycle();
    endtask

    task automatic req(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        p_rd[m]    = rd;
        p_wr[m]    = wr;
        p_addr[m]  = a;
        p_wdata[m] = d;
    endtask

    task automatic wait_done(input int maxc);
        int k;
        k = 0;
        while ((p_rd[0] || p_wr[0] || p_rd[1] || p_wr[1] || cyc + 1 < idle_at) && k < maxc) begin
            step();
            k++;
        end
        chk1("drain_bound", k < maxc, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; rst_drv = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
        for (int m = 0; m < 2; m++) begin
            p_rd[m] = 1'b0; p_wr[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0;
            mmem[m] = '0; exp_rdata[m] = '0;
        end
        idle_at = 0; acc_cyc = -1; rv_cyc = -1; acc_m = 0; rv_m = 0;
        acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; rv_data = '0;
        last = 1'b1; rst_prev = 1'b1;

        // Reset held with m0 requesting a write.
        req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0055);
        repeat (25) step();
        chk1("reset_s_we", s_we, 1'b0);
        chk1("reset_m0_wait", m0_wait, 1'b1);
        chk1("reset_m1_wait", m1_wait, 1'b1);
        chkw("reset_m0_rdata", m0_rdata, '0);
        chkw("reset_m1_rdata", m1_rdata, '0);
        rst_drv = 1'b1;
        step();
        step();
        chk1("release_s_we", s_we, 1'b1);
        chkw("release_s_wdata", s_wdata, 32'h0000_0055);

        // m0 single write.
        wait_done(50);
        req(0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step();
        step();
        chk1("wr_s_we", s_we, 1'b1);
        chkw("wr_s_addr", DW'(s_addr), 32'd1);
        chkw("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk1("wr_m0_wait", m0_wait, 1'b0);
        step();
        chk1("wr_s_we_drop", s_we, 1'b0);

        // m1 read of addr 0.
        wait_done(50);
        req(1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk1("rd_s_re", s_re, 1'b1);
        repeat (RD_LAT + 1) step();
        chk1("rd_m1_rdv", m1_rdv, 1'b1);
        chkw("rd_m1_rdata", m1_rdata, 32'h0000_0055);
        chk1("rd_m0_rdv", m0_rdv, 1'b0);

        // Both masters writing back to back.
        wait_done(50);
        grants.delete();
        for (int k = 0; k < 100 && grants.size() < 6; k++) begin
            if (!p_wr[0]) req(0, 1'b0, 1'b1, 1'b0, $urandom);
            if (!p_wr[1]) req(1, 1'b0, 1'b1, 1'b0, $urandom);
            step();
            if (!m0_wait) grants.push_back(0);
            if (!m1_wait) grants.push_back(1);
        end
        req(0, 1'b0, 1'b0, 1'b0, 32'h0);
        req(1, 1'b0, 1'b0, 1'b0, 32'h0);
        chkw("grant_count", DW'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
            chkw("grant_order", DW'(grants[i]), 32'd0);
`else
            chkw("grant_order", DW'(grants[i]), DW'(i % 2));
`endif
        end

        // m1 write arrives while an m0 read is waiting on the slave.
        wait_done(50);
        req(0, 1'b1, 1'b0, 1'b1, 32'h0);
        step();
        step();
        req(1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
        t_rv = -1;
        t_acc = -1;
        for (int k = 0; k < 20 && t_acc < 0; k++) begin
            step();
            if (m0_rdv) t_rv = cyc;
            if (!m1_wait) t_acc = cyc;
        end
        chk1("stall_seen", t_acc >= 0 && t_rv >= 0, 1'b1);
        chkw("stall_gap", DW'(t_acc - t_rv), 32'd2);

        // Reset during RD_WAIT, after m0 was granted last.
        wait_done(50);
        req(0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        step();
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
        req(0, 1'b0, 1'b1, 1'b0, 32'h1111_2222);
        req(1, 1'b0, 1'b1, 1'b1, 32'h3333_4444);
        step();
        step();
        chk1("post_reset_m0_wins", m0_wait, 1'b0);
        chk1("post_reset_m1_waits", m1_wait, 1'b1);
        chk1("post_reset_no_rdv", m0_rdv, 1'b0);

        // Random traffic with occasional resets and abandoned requests.
        for (int k = 0; k < 3000; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(p_rd[m] || p_wr[m])) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int op;
                        op = $urandom_range(1, 3);
                        req(m, op[0], op[1], AW'($urandom_range(0, 1)), $urandom);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    p_rd[m] = 1'b0;
                    p_wr[m] = 1'b0;
                end
            end
            rst_drv = ($urandom_range(0, 249) != 0);
            step();
        end
        rst_drv = 1'b1;
        wait_done(100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
